uart_rx_frame_ctrl: RTL and testbench

Frame controller for the UART receiver. It detects the start-bit falling edge on the serial line and enables the edge/bit counter and the data sampler. It consumes the counter's edge_count and bit_count plus the sampler's sampled_bit to deserialise 8 data bits (LSB first), check optional parity and the stop bit, and present a received byte with a one-cycle valid pulse.

---
 rtl/uart_rx_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// uart_rx_frame_ctrl : UART receive frame FSM (start, 8 data, parity, stop)
// Revision 1.0
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic [3:0]            bit_count,
    input  logic                  sampled_bit,
    output logic                  cnt_enable,
    output logic                  samp_enable,
    output logic [DATA_W-1:0]     p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] C_LAST_DATA_BIT = 4'(DATA_W);

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par_en;
    logic                r_par_typ;
    logic                r_par_mismatch;
    logic                w_bit_end;
    logic                w_par_expected;

    assign w_bit_end      = (r_state != S_IDLE) && (edge_count == prescale - PRESCALE_W'(1));
    assign w_par_expected = (^r_shift) ^ r_par_typ;

    // Enables and busy are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_shift        <= '0;
            r_par_en       <= 1'b0;
            r_par_typ      <= 1'b0;
            r_par_mismatch <= 1'b0;
            cnt_enable     <= 1'b0;
            samp_enable    <= 1'b0;
            busy           <= 1'b0;
            p_data         <= '0;
            data_valid     <= 1'b0;
            par_err        <= 1'b0;
            stp_err        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!rx_in) begin
                        r_state        <= S_START;
                        r_par_en       <= par_en;
                        r_par_typ      <= par_typ;
                        r_par_mismatch <= 1'b0;
                        cnt_enable     <= 1'b1;
                        samp_enable    <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        if (!sampled_bit) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state     <= S_IDLE;
                            cnt_enable  <= 1'b0;
                            samp_enable <= 1'b0;
                            busy        <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        // LSB arrives first, so shift right and insert at the top.
                        r_shift <= {sampled_bit, r_shift[DATA_W-1:1]};
                        if (bit_count == C_LAST_DATA_BIT) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_par_mismatch <= (sampled_bit != w_par_expected);
                        r_state        <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state     <= S_IDLE;
                        cnt_enable  <= 1'b0;
                        samp_enable <= 1'b0;
                        busy        <= 1'b0;
                        if (!r_par_mismatch && sampled_bit) begin
                            p_data     <= r_shift;
                            data_valid <= 1'b1;
                        end else begin
                            par_err <= r_par_mismatch;
                            stp_err <= ~sampled_bit;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    cnt_enable  <= 1'b0;
                    samp_enable <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_frame_ctrl : scoreboard bench with counter/sampler models
// Revision 1.0
// ============================================================================
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       cnt_enable;
    logic       samp_enable;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
        int         lat;
        int         at;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         start_cyc = 0;
    int         busy_len  = 0;
    logic       busy_d    = 1'b0;
    logic [7:0] good_data = 8'h00;

    uart_rx_frame_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .edge_count  (edge_count),
        .bit_count   (bit_count),
        .sampled_bit (sampled_bit),
        .cnt_enable  (cnt_enable),
        .samp_enable (samp_enable),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Edge/bit counter and mid-bit sampler models
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_count  <= 6'd0;
            bit_count   <= 4'd0;
            sampled_bit <= 1'b1;
        end else begin
            if (!cnt_enable) begin
                edge_count <= 6'd0;
                bit_count  <= 4'd0;
            end else if (edge_count == prescale - 6'd1) begin
                edge_count <= 6'd0;
                bit_count  <= bit_count + 4'd1;
            end else begin
                edge_count <= edge_count + 6'd1;
            end
            if (samp_enable && edge_count == (prescale >> 1))
                sampled_bit <= rx_in;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy && !busy_d) start_cyc <= cyc;
        if (!busy && busy_d) busy_len <= cyc - start_cyc;
        busy_d <= busy;
        if (data_valid || par_err || stp_err)
            obs_q.push_back(ev_t'{data_valid, par_err, stp_err, p_data, cyc - start_cyc, cyc});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_expected(input logic [7:0] d, input logic has_par, input logic par_bit,
                                 input logic stop_bit, input logic typ);
        ev_t  e;
        logic mism;
        mism  = has_par && (par_bit != ((^d) ^ typ));
        e.dv  = stop_bit && !mism;
        e.pe  = mism;
        e.se  = !stop_bit;
        if (e.dv) good_data = d;
        e.pd  = good_data;
        e.lat = (10 + int'(has_par)) * int'(prescale);
        e.at  = 0;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_bit, input bit flip_cfg);
        int p;
        p = int'(prescale);
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        if (flip_cfg) begin
            par_en  = ~par_en;
            par_typ = ~par_typ;
        end
        repeat (p - 2) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (has_par) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
        rx_in = 1'b1;
        if (flip_cfg) begin
            par_en  = ~par_en;
            par_typ = ~par_typ;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (p_data !== 8'h00) begin n_fail++; $display("FAIL reset_p_data: got %0h expected 0", p_data); end
        n_checks++;
        if ({data_valid, par_err, stp_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 000", {data_valid, par_err, stp_err});
        end
        n_checks++;
        if ({cnt_enable, samp_enable, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_enables: got %b expected 000", {cnt_enable, samp_enable, busy});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_parity_even();
        ev_t o, e;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        @(negedge clk);
        push_expected(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL even_event: got no pulse expected data_valid"); exp_q.delete();
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin
                n_fail++; $display("FAIL even_kind: got %b expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se});
            end
            n_checks++;
            if (o.pd !== e.pd) begin n_fail++; $display("FAIL even_p_data: got %0h expected %0h", o.pd, e.pd); end
            n_checks++;
            if (o.lat !== e.lat) begin n_fail++; $display("FAIL even_latency: got %0d expected %0d", o.lat, e.lat); end
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_parity_odd();
        ev_t o, e;
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
        @(negedge clk);
        push_expected(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL odd_event: got no pulse expected par_err"); exp_q.delete();
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin
                n_fail++; $display("FAIL odd_kind: got %b expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se});
            end
            n_checks++;
            if (o.pd !== e.pd) begin n_fail++; $display("FAIL odd_p_data_hold: got %0h expected %0h", o.pd, e.pd); end
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_stop_err();
        ev_t o, e;
        prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
        @(negedge clk);
        push_expected(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL stop_event: got no pulse expected stp_err"); exp_q.delete();
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.dv, o.pe, o.se} !== {e.dv, e.pe, e.se}) begin
                n_fail++; $display("FAIL stop_kind: got %b expected %b", {o.dv, o.pe, o.se}, {e.dv, e.pe, e.se});
            end
            n_checks++;
            if (o.pd !== e.pd) begin n_fail++; $display("FAIL stop_p_data_hold: got %0h expected %0h", o.pd, e.pd); end
        end
        repeat (32) @(negedge clk);
        n_checks++;
        if (busy_len !== 160) begin n_fail++; $display("FAIL stop_busy_len: got %0d expected 160", busy_len); end
    endtask

    task automatic test_glitch();
        prescale = 6'd16; par_en = 1'b0;
        @(negedge clk);
        drive_bit(1'b0, 3);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (busy_len !== 16) begin n_fail++; $display("FAIL glitch_start_len: got %0d expected 16", busy_len); end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL glitch_pulses: got %0d pulses expected 0", obs_q.size()); obs_q.delete();
        end
        n_checks++;
        if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL glitch_cnt_enable: got %b expected 0", cnt_enable); end
    endtask

    task automatic test_back_to_back();
        ev_t o1, o2, e;
        prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
        @(negedge clk);
        push_expected(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        push_expected(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400 && obs_q.size() < 2; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() < 2) begin
            n_fail++; $display("FAIL b2b_events: got %0d pulses expected 2", obs_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            o1 = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o1.dv, o1.pd} !== {e.dv, e.pd}) begin
                n_fail++; $display("FAIL b2b_first: got dv=%b data=%0h expected dv=%b data=%0h", o1.dv, o1.pd, e.dv, e.pd);
            end
            o2 = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++;
            if ({o2.dv, o2.pd} !== {e.dv, e.pd}) begin
                n_fail++; $display("FAIL b2b_second: got dv=%b data=%0h expected dv=%b data=%0h", o2.dv, o2.pd, e.dv, e.pd);
            end
            n_checks++;
            if (o2.at - o1.at !== 321) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d expected 321", o2.at - o1.at);
            end
            n_checks++;
            if (o2.lat !== e.lat) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", o2.lat, e.lat); end
        end
        repeat (64) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        ev_t o, e;
        logic [7:0] d;
        d = 8'h55;
        prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
        @(negedge clk);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
        drive_bit(d[3], 8);
        n_checks++;
        if ({busy, bit_count} !== {1'b1, 4'd4}) begin
            n_fail++; $display("FAIL mid_pre_state: got busy=%b bit=%0d expected busy=1 bit=4", busy, bit_count);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({p_data, data_valid, par_err, stp_err, cnt_enable, samp_enable, busy} !== 14'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %0h expected 0",
                               {p_data, data_valid, par_err, stp_err, cnt_enable, samp_enable, busy});
        end
        rx_in = 1'b1;
        good_data = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (48) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL mid_no_pulse: got %0d pulses expected 0", obs_q.size()); obs_q.delete();
        end
        push_expected(d, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(d, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL mid_recover_event: got no pulse expected data_valid"); exp_q.delete();
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.dv, o.pe, o.se, o.pd} !== {e.dv, e.pe, e.se, e.pd}) begin
                n_fail++; $display("FAIL mid_recover_frame: got %b/%0h expected %b/%0h",
                                   {o.dv, o.pe, o.se}, o.pd, {e.dv, e.pe, e.se}, e.pd);
            end
        end
        repeat (16) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_parity_odd();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL stray_pulses: got %0d unexpected pulses expected 0", obs_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
